// File: rtl/dmem_responder.sv
// Word-organised data-memory slave for the core load/store port.
// One request at a time, WAIT_CYCLES wait states, then a one-cycle response pulse.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        mem_state_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_wr_i,
    input  logic [3:0]  be_i,
    output logic [31:0] data_rd_o,
    output logic        rd_valid_o,
    output logic        wr_done_o,
    output logic        err_o,
    output logic        busy_o
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0] r_mem [2**DEPTH_LOG2];
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [29:0] r_waddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_data_rd;
    logic        r_rd_valid, r_wr_done, r_err, r_busy;

    logic                  w_sel_in, w_wr, w_oor, w_enter_resp, w_commit;
    logic [29:0]           w_waddr, w_off;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_unused_addr;

    assign w_unused_addr = ^addr_i[1:0];

    // With no wait states the access happens on the accept edge, so the live inputs are used.
    assign w_sel_in = (r_state == S_IDLE);
    assign w_wr     = w_sel_in ? mem_state_i    : r_wr;
    assign w_waddr  = w_sel_in ? addr_i[31:2]   : r_waddr;
    assign w_wdata  = w_sel_in ? data_wr_i      : r_wdata;
    assign w_be     = w_sel_in ? be_i           : r_be;

    // Word offset wraps, so addresses below BASE_ADDR land far out of range.
    assign w_off = w_waddr - BASE_ADDR[31:2];
    assign w_oor = |w_off[29:DEPTH_LOG2];
    assign w_idx = w_off[DEPTH_LOG2-1:0];

    assign w_enter_resp = (r_state == S_IDLE && req_i && NO_WAIT) ||
                          (r_state == S_WAIT && r_cnt == 4'd0);
    assign w_commit     = w_enter_resp && w_wr && !w_oor;

    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_data_rd  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_wr    <= mem_state_i;
                        r_waddr <= addr_i[31:2];
                        r_wdata <= data_wr_i;
                        r_be    <= be_i;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_INIT;
                        r_state <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                r_rd_valid <= !w_wr;
                r_wr_done  <= w_wr;
                r_err      <= w_oor;
                if (!w_wr) r_data_rd <= w_oor ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    assign data_rd_o  = r_data_rd;
    assign rd_valid_o = r_rd_valid;
    assign wr_done_o  = r_wr_done;
    assign err_o      = r_err;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) checked against
// a word-array memory model and latency rules derived from the wait-state count.
module tb_dmem_responder;
    localparam int          N    = 3;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] req;
    logic mem_state;
    logic [31:0] addr, wdata;
    logic [3:0] be;
    logic [31:0] rdata [N];
    logic [N-1:0] rdv, wrd, err, busy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .BASE_ADDR(BASE), .DEPTH_LOG2(10),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .req_i(req[g]), .mem_state_i(mem_state),
            .addr_i(addr), .data_wr_i(wdata), .be_i(be),
            .data_rd_o(rdata[g]), .rd_valid_o(rdv[g]), .wr_done_o(wrd[g]),
            .err_o(err[g]), .busy_o(busy[g])
        );
    end

    int WC [N] = '{1, 0, 3};
    int vec = 0, bad = 0;

    logic [31:0] mdl   [N][1024];
    bit          known [N][1024];

    int o_lat, o_busy, o_nrd, o_nwr, o_nerr;
    logic o_err;
    logic [31:0] o_data;

    function automatic bit oor(input logic [31:0] a);
        return (a - BASE) >= 32'h1000;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'h3FF);
    endfunction

    task automatic model_wr(input int d, input logic [31:0] a, input logic [31:0] dt, input logic [3:0] b);
        if (!oor(a)) begin
            for (int i = 0; i < 4; i++) if (b[i]) mdl[d][widx(a)][8*i +: 8] = dt[8*i +: 8];
            if (b == 4'hF) known[d][widx(a)] = 1'b1;
        end
    endtask

    // Issue one request and record what the response looked like; bounded at 40 cycles.
    task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] dt,
                       input logic [3:0] b, input bit ghost);
        o_lat = 0; o_busy = 0; o_nrd = 0; o_nwr = 0; o_nerr = 0; o_err = 1'b0;
        mem_state = wr; addr = a; wdata = dt; be = b; req[d] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1 && ghost) addr = a ^ 32'h30;
            else                 req[d] = 1'b0;
            if (busy[d]) o_busy++;
            if ((rdv[d] || wrd[d]) && o_lat == 0) begin o_lat = k; o_err = err[d]; end
            o_nrd += int'(rdv[d]); o_nwr += int'(wrd[d]); o_nerr += int'(err[d]);
            if (!busy[d]) break;
        end
        o_data = rdata[d];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            vec++; if ({busy[d], rdv[d], wrd[d], err[d]} !== 4'b0) begin bad++; $display("FAIL reset_flags[%0d]: got %b want 0000", d, {busy[d], rdv[d], wrd[d], err[d]}); end
            vec++; if (rdata[d] !== 32'd0) begin bad++; $display("FAIL reset_data[%0d]: got %h want 0", d, rdata[d]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0); model_wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
        vec++; if (o_lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", o_lat); end
        vec++; if (o_busy !== 2) begin bad++; $display("FAIL wr_busy_cycles: got %0d want 2", o_busy); end
        vec++; if (o_nwr !== 1 || o_nrd !== 0 || o_nerr !== 0) begin bad++; $display("FAIL wr_pulses: wr=%0d rd=%0d err=%0d want 1/0/0", o_nwr, o_nrd, o_nerr); end
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        vec++; if (o_lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", o_lat); end
        vec++; if (o_nrd !== 1 || o_nwr !== 0) begin bad++; $display("FAIL rd_pulses: rd=%0d wr=%0d want 1/0", o_nrd, o_nwr); end
        vec++; if (o_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", o_data); end
    endtask

    task automatic test_lanes;
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);   model_wr(0, 32'h20, 32'h11223344, 4'hF);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0); model_wr(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        txn(0, 1'b0, 32'h20, 32'h0, 4'b0001, 1'b0);
        vec++; if (o_data !== 32'h11BB33DD) begin bad++; $display("FAIL lane_merge: got %h want 11bb33dd", o_data); end
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
        vec++; if (o_nwr !== 1) begin bad++; $display("FAIL be0_wr_done: got %0d want 1", o_nwr); end
        vec++; if (o_data !== 32'h11BB33DD) begin bad++; $display("FAIL rd_hold_over_write: got %h want 11bb33dd", o_data); end
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        vec++; if (o_data !== 32'h11BB33DD) begin bad++; $display("FAIL be0_no_change: got %h want 11bb33dd", o_data); end
    endtask

    task automatic test_oor;
        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0); model_wr(0, 32'h0, 32'hCAFEF00D, 4'hF);
        txn(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 1'b0);
        vec++; if (o_nwr !== 1 || o_err !== 1'b1 || o_nerr !== 1) begin bad++; $display("FAIL oor_write: wr=%0d err=%b errcnt=%0d want 1/1/1", o_nwr, o_err, o_nerr); end
        txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        vec++; if (o_data !== 32'd0 || o_err !== 1'b1 || o_nrd !== 1) begin bad++; $display("FAIL oor_read: data=%h err=%b rd=%0d want 0/1/1", o_data, o_err, o_nrd); end
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        vec++; if (o_data !== 32'hCAFEF00D) begin bad++; $display("FAIL oor_ram_untouched: got %h want cafef00d", o_data); end
        txn(0, 1'b0, 32'h0FFC, 32'h0, 4'hF, 1'b0);
        vec++; if (o_nerr !== 0 || o_nrd !== 1) begin bad++; $display("FAIL last_word_in_range: err=%0d rd=%0d want 0/1", o_nerr, o_nrd); end
    endtask

    task automatic test_zero_wait;
        int mask;
        txn(1, 1'b1, 32'h8, 32'h0BADCAFE, 4'hF, 1'b0); model_wr(1, 32'h8, 32'h0BADCAFE, 4'hF);
        vec++; if (o_lat !== 1 || o_busy !== 1) begin bad++; $display("FAIL zw_latency: lat=%0d busy=%0d want 1/1", o_lat, o_busy); end
        mask = 0;
        mem_state = 1'b0; addr = 32'h8; be = 4'hF; req[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (rdv[1]) begin
                mask |= (1 << k);
                vec++; if (rdata[1] !== mdl[1][2]) begin bad++; $display("FAIL zw_b2b_data: got %h want %h", rdata[1], mdl[1][2]); end
            end
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        vec++; if (mask !== 32'h2A) begin bad++; $display("FAIL zw_b2b_spacing: got %h want 2a", mask); end
    endtask

    task automatic test_busy_ignore;
        int extra;
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        vec++; if (o_nrd !== 1 || o_lat !== 2) begin bad++; $display("FAIL ghost_single_resp: rd=%0d lat=%0d want 1/2", o_nrd, o_lat); end
        vec++; if (o_data !== mdl[0][widx(32'h10)]) begin bad++; $display("FAIL ghost_data: got %h want %h", o_data, mdl[0][widx(32'h10)]); end
        extra = 0;
        repeat (4) begin @(posedge clk); #1; extra += int'(busy[0]) + int'(rdv[0]) + int'(wrd[0]); end
        vec++; if (extra !== 0) begin bad++; $display("FAIL ghost_not_queued: activity=%0d want 0", extra); end
    endtask

    task automatic test_reset_wait;
        int act;
        txn(2, 1'b1, 32'h40, 32'h0F0F0F0F, 4'hF, 1'b0); model_wr(2, 32'h40, 32'h0F0F0F0F, 4'hF);
        vec++; if (o_lat !== 4 || o_busy !== 4) begin bad++; $display("FAIL w3_latency: lat=%0d busy=%0d want 4/4", o_lat, o_busy); end
        mem_state = 1'b1; addr = 32'h40; wdata = 32'h12345678; be = 4'hF; req[2] = 1'b1;
        @(posedge clk); #1; req[2] = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        vec++; if (busy[2] !== 1'b0 || wrd[2] !== 1'b0) begin bad++; $display("FAIL rst_wait_abort: busy=%b wr=%b want 0/0", busy[2], wrd[2]); end
        rst_n = 1'b1; act = 0;
        repeat (6) begin @(posedge clk); #1; act += int'(busy[2]) + int'(wrd[2]) + int'(rdv[2]); end
        vec++; if (act !== 0) begin bad++; $display("FAIL rst_wait_no_resp: activity=%0d want 0", act); end
        txn(2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        vec++; if (o_data !== 32'h0F0F0F0F) begin bad++; $display("FAIL rst_wait_ram_old: got %h want 0f0f0f0f", o_data); end
    endtask

    task automatic test_random;
        bit wr, have_rd;
        logic [31:0] a, dt, last_rd, exp;
        logic [3:0] b;
        for (int d = 0; d < N; d++) begin
            for (int w = 0; w < 16; w++) begin
                dt = $urandom;
                txn(d, 1'b1, BASE + 32'(w * 4), dt, 4'hF, 1'b0); model_wr(d, BASE + 32'(w * 4), dt, 4'hF);
            end
            have_rd = 1'b0; last_rd = '0;
            for (int n = 0; n < 50; n++) begin
                wr = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 9))
                    0:       a = BASE + 32'h1000 + 32'($urandom_range(0, 255) * 4);
                    1:       a = BASE - 32'd4;
                    default: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                endcase
                dt = $urandom; b = 4'($urandom_range(0, 15));
                txn(d, wr, a, dt, b, 1'b0);
                vec++; if (o_lat !== WC[d] + 1 || o_busy !== WC[d] + 1) begin bad++; $display("FAIL rnd_timing[%0d]: lat=%0d busy=%0d want %0d", d, o_lat, o_busy, WC[d] + 1); end
                vec++; if (o_nwr !== int'(wr) || o_nrd !== int'(!wr) || o_nerr !== int'(oor(a))) begin bad++; $display("FAIL rnd_pulses[%0d] a=%h: wr=%0d rd=%0d err=%0d", d, a, o_nwr, o_nrd, o_nerr); end
                if (wr) begin
                    model_wr(d, a, dt, b);
                    if (have_rd) begin
                        vec++; if (o_data !== last_rd) begin bad++; $display("FAIL rnd_rd_hold[%0d]: got %h want %h", d, o_data, last_rd); end
                    end
                end else begin
                    exp = oor(a) ? 32'd0 : mdl[d][widx(a)];
                    vec++; if (o_data !== exp) begin bad++; $display("FAIL rnd_rd_data[%0d] a=%h: got %h want %h", d, a, o_data, exp); end
                    have_rd = 1'b1; last_rd = exp;
                end
            end
        end
    endtask

    initial begin
        req = '0; mem_state = 1'b0; addr = '0; wdata = '0; be = '0; rst_n = 1'b0;
        test_reset;
        test_basic;
        test_lanes;
        test_oor;
        test_zero_wait;
        test_busy_ignore;
        test_reset_wait;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline core's load/store port: the slave end of the core's `mem_state`/address/write-data interface.
- Holds a word-organised RAM and accepts one request at a time.
- Applies programmable wait states, then returns read data or a write acknowledgement.
- Drives `busy_o`, which the pipeline control folds into its hold signal.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (1024 words = 4 KiB).
- WAIT_CYCLES, 1, extra wait states per access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_i  in  1  request valid; sampled only in IDLE.
- mem_state_i  in  1  direction; 1 = write (`MEM_WR_EN`), 0 = read.
- addr_i  in  32  byte address.
- data_wr_i  in  32  store data, already lane-aligned.
- be_i  in  4  byte enables; bit n covers data[8n+7:8n].
- data_rd_o  out  32  read data (full word).
- rd_valid_o  out  1  one-cycle pulse: data_rd_o is valid.
- wr_done_o  out  1  one-cycle pulse: write committed.
- err_o  out  1  one-cycle pulse with the response: address out of range.
- busy_o  out  1  request in flight; core must hold.

Behaviour:
Clock and reset (already decided):
- One clock, `clk`.
- Reset `rst_n` is synchronous, active-low.

Reset values:
- data_rd_o = 0, rd_valid_o = 0, wr_done_o = 0, err_o = 0, busy_o = 0, state = IDLE, wait counter = 0.
- RAM contents are not reset.

States: IDLE, WAIT, RESP.
- IDLE: busy_o = 0. On req_i = 1, latch addr, data, be and direction.
  - Next state is WAIT with counter = WAIT_CYCLES − 1 if WAIT_CYCLES > 0.
  - Next state is RESP if WAIT_CYCLES = 0.
- WAIT: busy_o = 1. Counter decrements each cycle; go to RESP when the counter is 0.
- RESP: busy_o = 1.
  - Exactly one of rd_valid_o or wr_done_o is high this cycle.
  - err_o is high in the same cycle if the address is out of range.
  - Next state is IDLE unconditionally.

Latency and throughput:
- Accept at edge T → response pulse visible in cycle T + WAIT_CYCLES + 1.
- Back in IDLE one cycle later; peak throughput is 1 request per WAIT_CYCLES + 2 cycles.
- busy_o is registered. It rises the cycle after accept and falls the cycle after RESP.

Address decode:
- off = addr − BASE_ADDR (32-bit wrap); word index = off[DEPTH_LOG2+1:2].
- addr[1:0] is ignored (accesses are word-aligned; lane selection uses be_i).
- Out of range when the unsigned off ≥ 4·2^DEPTH_LOG2. This includes addresses below BASE_ADDR, via wrap.

Writes:
- Commit on the edge entering RESP, with only the enabled lanes updated.
- be_i = 0: no change to the RAM, but wr_done_o still pulses.
- Out of range: the write is dropped, and wr_done_o and err_o pulse.

Reads:
- RAM read in the WAIT→RESP (or IDLE→RESP) transition; data_rd_o is registered.
- The full word is returned regardless of be_i; sign/zero extension belongs to the core.
- Out of range: data_rd_o = 0, and err_o pulses.
- data_rd_o holds its value until the next read response. Writes do not alter it.

Boundary conditions:
- req_i while busy (WAIT/RESP) is ignored and not queued. The core must keep the request stable until busy_o falls.
- Read immediately after a write to the same word returns the new data, since the write committed before the next accept.
- rst_n low in WAIT: request aborted, no RAM update, no response pulse, state IDLE next cycle.
- rst_n low in RESP: the commit already happened; pulses are cleared next cycle.
- Counter width is 4 bits; WAIT_CYCLES > 15 is illegal (elaboration-time check).

Test Plan:
1. WAIT_CYCLES = 1: write 0xDEADBEEF to 0x10 with be = 4'hF → wr_done_o at accept + 2, busy_o high 2 cycles. Then read 0x10 → rd_valid_o at accept + 2, data_rd_o = 0xDEADBEEF.
2. Byte lanes: word 0x20 = 0x11223344; write 0xAABBCCDD with be = 4'b0101 → read returns 0x11BB33DD. A write with be = 0 leaves the word unchanged but wr_done_o still pulses.
3. Out of range, DEPTH_LOG2 = 10: write to 0x1000 → wr_done_o and err_o together, RAM unchanged. Read 0x1000 → data_rd_o = 0, err_o = 1. Read 0x0FFC → err_o = 0.
4. WAIT_CYCLES = 0: read accepted at edge T → rd_valid_o in cycle T + 1. Back-to-back reads are accepted every 2 cycles.
5. Busy ignore: a second req_i asserted in the cycle after accept with a different address → exactly one response, for the first request only.
6. Reset mid-WAIT, WAIT_CYCLES = 3: write 0x12345678 to 0x40, pull rst_n low in the second WAIT cycle → no wr_done_o, busy_o = 0 after reset. A later read of 0x40 returns the old contents.
